// File: rtl/snoop_bus_ctrl.sv
// MSI snooping-bus controller: round-robin arbitration of N_CPU cache requests,
// snoop-response combining, memory read/flush sequencing and completion return.
module snoop_bus_ctrl #(
  parameter int N_CPU  = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CPU-1:0]          req,
  input  logic [2*N_CPU-1:0]        req_op,
  input  logic [ADDR_W*N_CPU-1:0]   req_addr,
  input  logic [DATA_W*N_CPU-1:0]   req_wdata,
  output logic [N_CPU-1:0]          grant,
  output logic                      bus_valid,
  output logic [1:0]                bus_op,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [$clog2(N_CPU)-1:0]  bus_src,
  input  logic [N_CPU-1:0]          snoop_hit,
  input  logic [N_CPU-1:0]          snoop_dirty,
  input  logic [DATA_W*N_CPU-1:0]   snoop_data,
  output logic                      done,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_shared,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack,
  output logic                      proto_err
);

  localparam int SRC_W = $clog2(N_CPU);

  localparam logic [1:0] OP_BUSRD  = 2'd0;
  localparam logic [1:0] OP_BUSUPG = 2'd2;
  localparam logic [1:0] OP_WB     = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_BCAST, S_SNOOP, S_MEM, S_DONE} state_t;

  state_t              r_state, w_next_state;
  logic [SRC_W-1:0]    r_rr, r_src, w_win, w_owner;
  logic                w_found;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_mem_wdata, r_resp_data, w_owner_data;
  logic                r_mem_we, r_resp_shared, r_proto_err;
  logic [N_CPU-1:0]    w_self, w_hit, w_dirty;
  logic                w_shared, w_any_dirty, w_multi_dirty;

  // Round-robin: scan starting just after the last served requester.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N_CPU; k++) begin
      if (!w_found && req[(int'(r_rr) + k) % N_CPU]) begin
        w_found = 1'b1;
        w_win   = SRC_W'((int'(r_rr) + k) % N_CPU);
      end
    end
  end

  always_comb begin
    w_self        = N_CPU'(1) << r_src;
    w_hit         = snoop_hit & ~w_self;
    w_dirty       = snoop_dirty & ~w_self;
    w_shared      = |w_hit;
    w_any_dirty   = 1'b0;
    w_multi_dirty = 1'b0;
    w_owner       = '0;
    for (int i = 0; i < N_CPU; i++) begin
      if (w_dirty[i]) begin
        if (w_any_dirty) w_multi_dirty = 1'b1;
        else             w_owner       = SRC_W'(i);
        w_any_dirty = 1'b1;
      end
    end
    w_owner_data = snoop_data[w_owner*DATA_W +: DATA_W];
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = S_BCAST;
      S_BCAST: w_next_state = S_SNOOP;
      S_SNOOP: w_next_state = (r_op == OP_BUSUPG) ? S_DONE : S_MEM;
      S_MEM:   if (mem_ack) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr          <= SRC_W'(N_CPU - 1);
      r_src         <= '0;
      r_op          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_mem_we      <= 1'b0;
      r_mem_wdata   <= '0;
      r_resp_data   <= '0;
      r_resp_shared <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_src         <= w_win;
            r_op          <= req_op[w_win*2 +: 2];
            r_addr        <= req_addr[w_win*ADDR_W +: ADDR_W];
            r_wdata       <= req_wdata[w_win*DATA_W +: DATA_W];
            r_resp_data   <= '0;
            r_resp_shared <= 1'b0;
          end
        end
        S_SNOOP: begin
          if (w_multi_dirty) r_proto_err <= 1'b1;
          r_resp_shared <= (r_op == OP_BUSRD) && w_shared;
          if (r_op == OP_WB) begin
            r_mem_we    <= 1'b1;
            r_mem_wdata <= r_wdata;
          end else if (w_any_dirty) begin
            // Dirty owner flushes: memory and requester both take its copy.
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_owner_data;
            r_resp_data <= w_owner_data;
          end else begin
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
          end
        end
        S_MEM: begin
          if (mem_ack && !r_mem_we) r_resp_data <= mem_rdata;
        end
        S_DONE: r_rr <= r_src;
        default: ;
      endcase
    end
  end

  always_comb begin
    grant       = (r_state != S_IDLE) ? (N_CPU'(1) << r_src) : '0;
    bus_valid   = (r_state == S_BCAST);
    bus_op      = bus_valid ? r_op : '0;
    bus_addr    = bus_valid ? r_addr : '0;
    bus_src     = bus_valid ? r_src : '0;
    mem_req     = (r_state == S_MEM);
    mem_we      = mem_req & r_mem_we;
    mem_addr    = mem_req ? r_addr : '0;
    mem_wdata   = mem_we ? r_mem_wdata : '0;
    done        = (r_state == S_DONE);
    resp_data   = done ? r_resp_data : '0;
    resp_shared = done & r_resp_shared;
    proto_err   = r_proto_err;
  end

endmodule
